pipelined_logic_unit: RTL and testbench
=======================================

// Module: pipelined_logic_unit
// PURPOSE
//  Multi-mode bitwise logic unit (AND/OR/XOR/NOR) on two NB_BITS operands. Result
//  passes through a DEPTH-stage elastic pipeline with valid/ready handshake.
//  Backpressure from downstream stalls the pipeline without dropping or duplicating
//  results. Serves the execute stage and any datapath that needs timing-isolated logic ops.
// PARAMETERS
//  NB_BITS  32  operand/result width, >= 1
//  DEPTH    2   pipeline register stages, >= 1 (latency in cycles when not stalled)
// PORTS
//  clk_i    in   1        clock, all state updates on rising edge
//  rst_i    in   1        asynchronous reset, active-high
//  a_i      in   NB_BITS  operand A
//  b_i      in   NB_BITS  operand B
//  op_i     in   2        operation, logic_unit_pkg::logic_op_t
//  valid_i  in   1        upstream presents a_i/b_i/op_i
//  ready_o  out  1        unit accepts input this cycle
//  s_o      out  NB_BITS  result at pipeline head
//  valid_o  out  1        s_o holds a valid result
//  ready_i  in   1        downstream accepts s_o this cycle
//  zero_o   out  1        (LOGIC_ZERO_FLAG_EN only) s_o == 0
// BEHAVIOUR
//  - Reset (async assert, sync release on clk_i): all stage valid bits 0, all stage data 0;
//    s_o=0, valid_o=0, zero_o=0. ready_o=1 while rst_i is low after reset (pipeline empty).
//    Reset mid-operation discards every in-flight result; no output after release until new input.
//  - Ops: LOP_AND=0 a&b, LOP_OR=1 a|b, LOP_XOR=2 a^b, LOP_NOR=3 ~(a|b). Evaluated combinationally
//    before stage 0; later stages carry the result unchanged. Full-width, no carry/sign.
//  - Transfer in: valid_i && ready_o. Transfer out: valid_o && ready_i.
//  - Stage k (0..DEPTH-1) loads when en[k] = ~v[k] | en[k+1]; en[DEPTH] = ready_i.
//    On en[k]: v[k] <= v[k-1] (v[-1] = valid_i), data[k] <= data[k-1]. Data loads only when the
//    incoming valid is 1; bubbles do not overwrite data.
//  - ready_o = en[0] (combinational through stage chain; no ready_i-to-ready_o register).
//  - valid_o = v[DEPTH-1], s_o = data[DEPTH-1].
//  - Latency: result of input accepted at edge n appears with valid_o=1 after edge n+DEPTH-1
//    (DEPTH cycles in total when ready_i stays 1). Throughput 1 result/cycle.
//  - Stall: while valid_o && ~ready_i, s_o/valid_o/zero_o hold stable; bubbles ahead collapse
//    (empty stages keep filling). When all DEPTH stages are valid and ready_i=0, ready_o=0.
//  - Full pipeline + ready_i=1 + valid_i=1 in same cycle: simultaneous in/out, no bubble.
//  - valid_i=1 while ready_o=0: input not taken; upstream must hold it (not checked).
//  - Inputs ignored (X-tolerant) when valid_i=0.
// CONFIGURATION
//  - LOGIC_ZERO_FLAG_EN defined: each stage carries an extra zero bit computed at stage 0 input
//    (result == 0); zero_o = head zero bit, reset 0, same stall/hold rules as s_o.
//  - Not defined: zero_o port absent; no extra flops.
// STRUCTURE
//  - logic_unit_pkg: typedef enum logic [1:0] logic_op_t {LOP_AND, LOP_OR, LOP_XOR, LOP_NOR};
//    function logic_eval(a, b, op) not parametric -> evaluation stays in module.
//  - Sub-module pipe_stage #(NB_BITS_W) : one elastic slot (v, data, en_in, en_out), generate-
//    replicated DEPTH times; width includes zero bit when LOGIC_ZERO_FLAG_EN.
// TESTING
//  1. Reset then a=0xF0F0_F0F0, b=0x0FF0_0FF0 each op, ready_i=1, DEPTH=2 -> after 2 cycles
//     s_o = 0x00F0_00F0 / 0xFFF0_FFF0 / 0xFF00_FF00 / 0x000F_000F in order, valid_o=1 each.
//  2. Stream 8 back-to-back inputs, ready_i=1 -> 8 consecutive valid_o cycles, order preserved.
//  3. ready_i=0 with 3 inputs offered, DEPTH=2 -> 2 accepted, ready_o=0 on third, s_o holds
//     first result; ready_i=1 -> third accepted same cycle first leaves, no loss/duplicate.
//  4. Assert rst_i asynchronously (between edges) with 2 in flight -> valid_o=0, s_o=0
//     immediately; after release no output until new input.
//  5. LOGIC_ZERO_FLAG_EN: a=b=0x1234_5678, LOP_XOR -> s_o=0, zero_o=1; LOP_OR -> zero_o=0.
//  6. DEPTH=1, NB_BITS=1: a=1,b=0,LOP_NOR -> s_o=0 next cycle; random ready_i/valid_i
//     vs scoreboard, 10k cycles, no mismatch.

Source files
------------

// File: rtl/logic_unit_pkg.sv
// Shared types for the pipelined logic unit: operation encoding and the optional
// zero-flag width (LOGIC_ZERO_FLAG_EN adds one bit carried alongside each result).
package logic_unit_pkg;

  typedef enum logic [1:0] {
    LOP_AND = 2'd0,
    LOP_OR  = 2'd1,
    LOP_XOR = 2'd2,
    LOP_NOR = 2'd3
  } logic_op_t;

`ifdef LOGIC_ZERO_FLAG_EN
  localparam int ZERO_FLAG_W = 1;
`else
  localparam int ZERO_FLAG_W = 0;
`endif

endpackage

// File: rtl/pipelined_logic_unit_if.sv
// Valid/ready operand and result bus of the pipelined logic unit.
// zero_o exists only when LOGIC_ZERO_FLAG_EN is defined.
interface pipelined_logic_unit_if
  import logic_unit_pkg::*;
#(
  parameter int NB_BITS = 32
) ();

  logic [NB_BITS-1:0] a_i;
  logic [NB_BITS-1:0] b_i;
  logic_op_t          op_i;
  logic               valid_i;
  logic               ready_o;
  logic [NB_BITS-1:0] s_o;
  logic               valid_o;
  logic               ready_i;
`ifdef LOGIC_ZERO_FLAG_EN
  logic               zero_o;
`endif

  modport slave (
    input  a_i, b_i, op_i, valid_i, ready_i,
`ifdef LOGIC_ZERO_FLAG_EN
    output zero_o,
`endif
    output ready_o, s_o, valid_o
  );

  modport master (
    output a_i, b_i, op_i, valid_i, ready_i,
`ifdef LOGIC_ZERO_FLAG_EN
    input  zero_o,
`endif
    input  ready_o, s_o, valid_o
  );

endinterface

// File: rtl/pipe_stage.sv
// One elastic pipeline slot: loads when empty or when the slot downstream loads.
// Bubbles advance the valid bit but never overwrite the held data.
module pipe_stage #(
  parameter int NB_BITS_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 v_in,
  input  logic [NB_BITS_W-1:0] d_in,
  input  logic                 en_in,
  output logic                 v_out,
  output logic [NB_BITS_W-1:0] d_out,
  output logic                 en_out
);

  logic                 v_reg;
  logic [NB_BITS_W-1:0] d_reg;

  assign en_out = ~v_reg | en_in;
  assign v_out  = v_reg;
  assign d_out  = d_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_reg <= 1'b0;
      d_reg <= '0;
    end else if (en_out) begin
      v_reg <= v_in;
      if (v_in) begin
        d_reg <= d_in;
      end
    end
  end

endmodule

// File: rtl/pipelined_logic_unit.sv
// AND/OR/XOR/NOR unit feeding a DEPTH-stage elastic valid/ready pipeline.
// LOGIC_ZERO_FLAG_EN carries a result==0 bit through every stage to zero_o.
module pipelined_logic_unit
  import logic_unit_pkg::*;
#(
  parameter int NB_BITS = 32,
  parameter int DEPTH   = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pipelined_logic_unit_if.slave bus
);

  localparam int W = NB_BITS + ZERO_FLAG_W;

  logic [NB_BITS-1:0] result;
  logic [W-1:0]       data_chain  [DEPTH+1];
  logic               valid_chain [DEPTH+1];
  logic               en_chain    [DEPTH+1];

  // Plain case: op_i may be garbage while valid_i is low.
  always_comb begin
    result = '0;
    case (bus.op_i)
      LOP_AND: result = bus.a_i & bus.b_i;
      LOP_OR:  result = bus.a_i | bus.b_i;
      LOP_XOR: result = bus.a_i ^ bus.b_i;
      default: result = ~(bus.a_i | bus.b_i);
    endcase
  end

`ifdef LOGIC_ZERO_FLAG_EN
  assign data_chain[0] = {(result == '0), result};
`else
  assign data_chain[0] = result;
`endif
  assign valid_chain[0]  = bus.valid_i;
  assign en_chain[DEPTH] = bus.ready_i;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      pipe_stage #(.NB_BITS_W(W)) u_stage (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .v_in   (valid_chain[gi]),
        .d_in   (data_chain[gi]),
        .en_in  (en_chain[gi+1]),
        .v_out  (valid_chain[gi+1]),
        .d_out  (data_chain[gi+1]),
        .en_out (en_chain[gi])
      );
    end
  endgenerate

  assign bus.ready_o = en_chain[0];
  assign bus.valid_o = valid_chain[DEPTH];
  assign bus.s_o     = data_chain[DEPTH][NB_BITS-1:0];
`ifdef LOGIC_ZERO_FLAG_EN
  assign bus.zero_o  = data_chain[DEPTH][NB_BITS];
`endif

endmodule

// File: tb/tb_pipelined_logic_unit.sv
// Scoreboard bench for pipelined_logic_unit (NB_BITS=32, DEPTH=2); zero-flag
// checks are compiled in when LOGIC_ZERO_FLAG_EN is defined.
module tb_pipelined_logic_unit;
  import logic_unit_pkg::*;

  localparam int NB = 32;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [NB-1:0] sb_q [$];
  logic [NB-1:0] exp_a;

  pipelined_logic_unit_if #(.NB_BITS(NB)) bus ();

  pipelined_logic_unit #(.NB_BITS(NB), .DEPTH(2)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [NB-1:0] model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                          input logic [1:0] op);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~(a | b);
    endcase
  endfunction

  // One clock: scoreboard work at the falling edge, returns 1 time unit after the rising edge.
  task automatic tick();
    logic [NB-1:0] exp_s;
    @(negedge clk_i);
    if (!rst_i) begin
      if (bus.valid_o && bus.ready_i) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected s_o=%h required=no output", bus.s_o);
        end else begin
          exp_s = sb_q.pop_front();
          if (bus.s_o !== exp_s) begin
            errors++;
            $display("FAIL sb_data s_o=%h required=%h", bus.s_o, exp_s);
          end
`ifdef LOGIC_ZERO_FLAG_EN
          checks++;
          if (bus.zero_o !== (exp_s == '0)) begin
            errors++;
            $display("FAIL sb_zero zero_o=%b required=%b", bus.zero_o, (exp_s == '0));
          end
`endif
        end
      end
      if (bus.valid_i && bus.ready_o)
        sb_q.push_back(model(bus.a_i, bus.b_i, bus.op_i));
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic [1:0] op);
    bus.valid_i = v;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.op_i    = logic_op_t'(op);
  endtask

  task automatic test_reset();
    drive(1'b0, '0, '0, 2'd0);
    bus.ready_i = 1'b1;
    rst_i = 1'b1;
    #12;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.s_o !== '0) begin
      errors++;
      $display("FAIL reset_out valid_o=%b s_o=%h required=0/0", bus.valid_o, bus.s_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    checks++;
    if (bus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready ready_o=%b required=1", bus.ready_o);
    end
  endtask

  task automatic test_ops();
    logic [NB-1:0] req [4];
    req[0] = 32'h00F0_00F0;
    req[1] = 32'hFFF0_FFF0;
    req[2] = 32'hFF00_FF00;
    req[3] = 32'h000F_000F;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 2'(k));
      tick();
      drive(1'b0, '0, '0, 2'd0);
      checks++;
      if (bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL op%0d_early valid_o=%b required=0", k, bus.valid_o);
      end
      tick();
      checks++;
      if (bus.valid_o !== 1'b1 || bus.s_o !== req[k]) begin
        errors++;
        $display("FAIL op%0d valid_o=%b s_o=%h required=1/%h", k, bus.valid_o, bus.s_o, req[k]);
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
      else       drive(1'b0, '0, '0, 2'd0);
      tick();
      checks++;
      if (bus.valid_o !== ((i >= 1 && i <= 8) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL b2b_valid cycle=%0d valid_o=%b", i, bus.valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.ready_i = 1'b0;
    exp_a = model(32'h1111_0000, 32'h0101_0101, 2'd1);
    drive(1'b1, 32'h1111_0000, 32'h0101_0101, 2'd1);
    tick();
    drive(1'b1, 32'hAAAA_5555, 32'hFFFF_0000, 2'd2);
    tick();
    drive(1'b1, 32'h1234_0000, 32'h00FF_00FF, 2'd3);
    for (int h = 0; h < 3; h++) begin
      #1;
      checks++;
      if (bus.ready_o !== 1'b0 || bus.valid_o !== 1'b1 || bus.s_o !== exp_a) begin
        errors++;
        $display("FAIL stall_hold h=%0d ready_o=%b valid_o=%b s_o=%h required=0/1/%h",
                 h, bus.ready_o, bus.valid_o, bus.s_o, exp_a);
      end
      if (h < 2) tick();
    end
    bus.ready_i = 1'b1;
    #1;
    checks++;
    if (bus.ready_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_release ready_o=%b required=1", bus.ready_o);
    end
    tick();
    drive(1'b0, '0, '0, 2'd0);
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain pending=%0d required=0", sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 2'd0);
    tick();
    drive(1'b1, 32'hCAFE_F00D, 32'h0000_FFFF, 2'd1);
    tick();
    drive(1'b0, '0, '0, 2'd0);
    #2;
    rst_i = 1'b1;
    #1;
    checks++;
    if (bus.valid_o !== 1'b0 || bus.s_o !== '0) begin
      errors++;
      $display("FAIL async_rst valid_o=%b s_o=%h required=0/0", bus.valid_o, bus.s_o);
    end
    sb_q.delete();
    tick();
    rst_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.valid_o !== 1'b0) begin
        errors++;
        $display("FAIL post_rst_idle cycle=%0d valid_o=%b required=0", i, bus.valid_o);
      end
    end
  endtask

`ifdef LOGIC_ZERO_FLAG_EN
  task automatic test_zero_flag();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 32'h1234_5678, 32'h1234_5678, (k == 0) ? 2'd2 : 2'd1);
      tick();
      drive(1'b0, '0, '0, 2'd0);
      tick();
      checks++;
      if (bus.valid_o !== 1'b1 || bus.zero_o !== (k == 0)) begin
        errors++;
        $display("FAIL zero_flag k=%0d valid_o=%b zero_o=%b required=1/%b",
                 k, bus.valid_o, bus.zero_o, (k == 0));
      end
      tick();
    end
  endtask
`endif

  task automatic test_random();
    logic held;
    held = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bus.ready_i = ($urandom_range(0, 9) < 6);
      if (!held) begin
        if ($urandom_range(0, 9) < 7) drive(1'b1, $urandom, $urandom, 2'($urandom_range(0, 3)));
        else                          drive(1'b0, $urandom, $urandom, 2'($urandom_range(0, 3)));
      end
      #1;
      held = bus.valid_i && !bus.ready_o;
      tick();
    end
    drive(1'b0, '0, '0, 2'd0);
    bus.ready_i = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL random_drain pending=%0d required=0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
`ifdef LOGIC_ZERO_FLAG_EN
    test_zero_flag();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
